conv3x3_engine: RTL and testbench

CONV3X3_ENGINE -- requirements
Module: conv3x3_engine

---
 rtl/conv3x3_engine.sv | 170 +++++++++++++++++
 tb/tb_conv3x3_engine.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/conv3x3_engine.sv
// 3x3 zero-padded convolution over an image held in a source SRAM; results go to a destination SRAM.
// Each output pixel takes 9 tap reads, one drain cycle for the last read, then one write cycle.
module conv3x3_engine #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 256,
  parameter int SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [35:0] coef,
  output logic        src_en,
  output logic        src_wen,
  output logic [14:0] src_addr,
  input  logic [7:0]  src_q,
  output logic        dst_en,
  output logic        dst_wen,
  output logic [14:0] dst_addr,
  output logic [7:0]  dst_d,
  output logic        busy,
  output logic        done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [2:0] {IDLE, READ, LAST, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [3:0]         tap_q, tap_d;
  logic [3:0]         ptap_q, ptap_d;
  logic               pv_q, pv_d;
  logic [35:0]        coef_q, coef_d;
  logic signed [15:0] acc_q, acc_d;

  logic               src_en_q, src_en_d;
  logic [14:0]        src_addr_q, src_addr_d;
  logic               dst_en_q, dst_en_d;
  logic               dst_wen_q, dst_wen_d;
  logic [14:0]        dst_addr_q, dst_addr_d;
  logic [7:0]         dst_d_q, dst_d_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic signed [8:0]  sq;
  logic signed [3:0]  c;
  logic signed [15:0] prod;
  logic signed [15:0] sh;
  int                 nx, ny, sa, da;
  logic               inb;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    tap_d   = tap_q;
    ptap_d  = tap_q;
    pv_d    = 1'b0;
    coef_d  = coef_q;
    sq      = signed'({1'b0, src_q});
    c       = coef_q[4*int'(ptap_q) +: 4];
    prod    = 16'(sq) * 16'(c);
    // pv_q marks that last cycle issued an in-bounds read, so src_q is valid now
    acc_d   = pv_q ? acc_q + prod : acc_q;

    case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        x_d     = '0;
        y_d     = '0;
        tap_d   = '0;
        acc_d   = '0;
        coef_d  = coef;
      end
      READ: begin
        pv_d = src_en_q;
        if (tap_q == 4'd8) state_d = LAST;
        else tap_d = tap_q + 4'd1;
      end
      LAST:  state_d = WRITE;
      WRITE: begin
        acc_d = '0;
        tap_d = '0;
        state_d = READ;
        if (x_q == XW'(IMG_W-1)) begin
          x_d = '0;
          if (y_q == YW'(IMG_H-1)) state_d = DONE;
          else y_d = y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // outputs are decoded from the next state so they are registered yet aligned with it
    nx  = int'(x_d) + (int'(tap_d) % 3) - 1;
    ny  = int'(y_d) + (int'(tap_d) / 3) - 1;
    inb = (nx >= 0) && (nx < IMG_W) && (ny >= 0) && (ny < IMG_H);
    sa  = ny * IMG_W + nx;
    da  = int'(y_d) * IMG_W + int'(x_d);

    src_en_d   = (state_d == READ) && inb;
    src_addr_d = src_en_d ? 15'(sa) : '0;
    dst_en_d   = (state_d == WRITE);
    dst_wen_d  = !dst_en_d;
    dst_addr_d = dst_en_d ? 15'(da) : '0;

    sh = acc_d >>> SHIFT;
    if (!dst_en_d)            dst_d_d = '0;
    else if (sh < 16'sd0)     dst_d_d = 8'd0;
    else if (sh > 16'sd255)   dst_d_d = 8'd255;
    else                      dst_d_d = sh[7:0];

    busy_d = (state_d == READ) || (state_d == LAST) || (state_d == WRITE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      tap_q      <= '0;
      ptap_q     <= '0;
      pv_q       <= 1'b0;
      coef_q     <= '0;
      acc_q      <= '0;
      src_en_q   <= 1'b0;
      src_addr_q <= '0;
      dst_en_q   <= 1'b0;
      dst_wen_q  <= 1'b1;
      dst_addr_q <= '0;
      dst_d_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      tap_q      <= tap_d;
      ptap_q     <= ptap_d;
      pv_q       <= pv_d;
      coef_q     <= coef_d;
      acc_q      <= acc_d;
      src_en_q   <= src_en_d;
      src_addr_q <= src_addr_d;
      dst_en_q   <= dst_en_d;
      dst_wen_q  <= dst_wen_d;
      dst_addr_q <= dst_addr_d;
      dst_d_q    <= dst_d_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign src_en   = src_en_q;
  assign src_wen  = 1'b1;
  assign src_addr = src_addr_q;
  assign dst_en   = dst_en_q;
  assign dst_wen  = dst_wen_q;
  assign dst_addr = dst_addr_q;
  assign dst_d    = dst_d_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine on a 4x3 image with hand-computed expected outputs.
module tb_conv3x3_engine;

  logic        gclk = 1'b0;
  logic        rst, start;
  logic [35:0] coef;
  logic        src_en, src_wen, dst_en, dst_wen, busy, done;
  logic [14:0] src_addr, dst_addr;
  logic [7:0]  src_q, dst_d;

  logic [7:0]  mem  [0:15];
  logic [7:0]  dmem [0:15];
  logic        en_s [0:8];
  logic [14:0] ad_s [0:8];
  int          n_cmp = 0, n_err = 0;
  int          busy_cnt, done_cnt, wr_cnt;

  always #5 gclk = ~gclk;

  conv3x3_engine #(.IMG_W(4), .IMG_H(3), .SHIFT(0)) dut (
    .clk(gclk), .rst(rst), .start(start), .coef(coef),
    .src_en(src_en), .src_wen(src_wen), .src_addr(src_addr), .src_q(src_q),
    .dst_en(dst_en), .dst_wen(dst_wen), .dst_addr(dst_addr), .dst_d(dst_d),
    .busy(busy), .done(done)
  );

  always @(posedge gclk) if (src_en) src_q <= mem[src_addr[3:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] one_tap(input int k, input logic [3:0] v);
    logic [35:0] r;
    r = '0;
    r[4*k +: 4] = v;
    return r;
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v;
  endtask

  // entered at a negedge; returns at a negedge a few cycles after done
  task automatic run_pass(input int restart_at, input logic [35:0] coef_mid);
    int done_c;
    for (int i = 0; i < 16; i++) dmem[i] = 8'hAA;
    busy_cnt = 0; done_cnt = 0; wr_cnt = 0; done_c = -1;
    start = 1'b1;
    @(negedge gclk);
    start = 1'b0;
    coef = coef_mid;
    for (int c = 0; c < 160; c++) begin
      start = (c == restart_at);
      if (busy) busy_cnt++;
      if (c < 9) begin en_s[c] = src_en; ad_s[c] = src_addr; end
      if (dst_en && !dst_wen) begin dmem[dst_addr[3:0]] = dst_d; wr_cnt++; end
      if (done) begin done_cnt++; if (done_c < 0) done_c = c; end
      if (done_c >= 0 && c >= done_c + 3) break;
      @(negedge gclk);
    end
    start = 1'b0;
    chk("pass_done_once", done_cnt, 1);
    chk("pass_busy_cycles", busy_cnt, 132);
    chk("pass_writes", wr_cnt, 12);
  endtask

  task automatic chk_img(input string tag, input logic [7:0] exp [0:11]);
    for (int i = 0; i < 12; i++) chk($sformatf("%s[%0d]", tag, i), dmem[i], exp[i]);
  endtask

  logic [7:0] e_id   [0:11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
  logic [7:0] e_box  [0:11] = '{40, 60, 60, 40, 60, 90, 90, 60, 40, 60, 60, 40};
  logic [7:0] e_rt   [0:11] = '{1, 2, 3, 0, 5, 6, 7, 0, 9, 10, 11, 0};
  logic [7:0] e_dn2  [0:11] = '{8, 10, 12, 14, 16, 18, 20, 22, 0, 0, 0, 0};
  logic [7:0] e_up2  [0:11] = '{0, 0, 0, 0, 0, 2, 4, 6, 8, 10, 12, 14};
  logic [7:0] e_hi   [0:11] = '{255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255};
  logic [7:0] e_lo   [0:11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  logic       e_en   [0:8]  = '{0, 0, 0, 0, 1, 1, 0, 1, 1};
  logic [14:0] e_ad  [0:8]  = '{0, 0, 0, 0, 0, 1, 0, 4, 5};

  initial begin
    rst = 1'b1; start = 1'b1; coef = '0;
    fill_ramp();
    repeat (3) @(negedge gclk);
    rst = 1'b0; start = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_src_en", src_en, 0);
    chk("rst_src_wen", src_wen, 1);
    chk("rst_src_addr", src_addr, 0);
    chk("rst_dst_en", dst_en, 0);
    chk("rst_dst_wen", dst_wen, 1);
    chk("rst_dst_addr", dst_addr, 0);
    chk("rst_dst_d", dst_d, 0);
    @(negedge gclk);

    // identity kernel; a second start mid-pass must be ignored
    coef = one_tap(4, 4'd1);
    run_pass(40, coef);
    chk_img("identity", e_id);
    for (int t = 0; t < 9; t++) begin
      chk($sformatf("p00_en[%0d]", t), en_s[t], e_en[t]);
      if (e_en[t]) chk($sformatf("p00_addr[%0d]", t), ad_s[t], e_ad[t]);
    end

    coef = 36'h111111111;
    fill_const(8'd10);
    run_pass(-1, coef);
    chk_img("box", e_box);

    // coef scrambled right after start: latched taps must still be used
    fill_ramp();
    coef = one_tap(5, 4'd1);
    run_pass(-1, 36'hFFFFFFFFF);
    chk_img("right", e_rt);

    coef = one_tap(7, 4'd2);
    run_pass(-1, coef);
    chk_img("down2", e_dn2);

    coef = one_tap(1, 4'd2);
    run_pass(-1, coef);
    chk_img("up2", e_up2);

    fill_const(8'd200);
    coef = one_tap(4, 4'd7);
    run_pass(-1, coef);
    chk_img("clamp_hi", e_hi);

    coef = one_tap(4, 4'hF);
    run_pass(-1, coef);
    chk_img("clamp_lo", e_lo);

    // abort mid-pass with reset, then restart from (0,0)
    fill_ramp();
    coef = one_tap(4, 4'd1);
    start = 1'b1;
    @(negedge gclk);
    start = 1'b0;
    repeat (50) @(negedge gclk);
    rst = 1'b1; start = 1'b1;
    @(negedge gclk);
    rst = 1'b0; start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_src_en", src_en, 0);
    wr_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (dst_en) wr_cnt++;
      if (done) done_cnt++;
      @(negedge gclk);
    end
    chk("abort_no_write", wr_cnt, 0);
    chk("abort_no_done", done_cnt, 0);
    run_pass(-1, coef);
    chk_img("restart", e_id);
    chk("restart_tap4_en", en_s[4], 1);
    chk("restart_tap4_addr", ad_s[4], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
